serial_subtractor: RTL and testbench

- Bit-serial, multi-cycle subtractor; the inverse operation of the team's parallel ripple adder.
- Computes diff = a - b - bin, one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- Used where area matters more than latency. It replaces a WIDTH-wide combinational borrow chain.
- Start/busy/done handshake toward an upstream sequencer.

---
 rtl/serial_subtractor.sv | 111 +++++++++++
 tb/tb_serial_subtractor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;

  logic             w_d;
  logic             w_borrow_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Single full-subtractor cell working on the current LSBs.
  always_comb begin
    w_d           = r_sa[0] ^ r_sb[0] ^ r_borrow;
    w_borrow_next = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_borrow);
    w_last        = (r_cnt == CNT_W'(WIDTH - 1));
    w_res_next    = {w_d, r_res[WIDTH-1:1]};
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (r_state == StIdle && start) begin
        r_a_msb <= a[WIDTH-1];
        r_b_msb <= b[WIDTH-1];
      end
      // w_d on the last step is the final diff MSB.
      if (r_state == StRun && w_last) begin
        ovf <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_sa     <= '0;
      r_sb     <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_sa     <= a;
            r_sb     <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
            r_state  <= StRun;
            busy     <= 1'b1;
          end
        end
        StRun: begin
          r_sa     <= r_sa >> 1;
          r_sb     <= r_sb >> 1;
          r_res    <= w_res_next;
          r_borrow <= w_borrow_next;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b1;
            diff    <= w_res_next;
            bout    <= w_borrow_next;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed plan items plus random traffic,
// checked every cycle against an arithmetic model. Honours SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(WIDTH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: result is plain modular arithmetic, available WIDTH edges after accept.
  logic             m_busy = 1'b0;
  logic             m_done = 1'b0;
  logic [WIDTH-1:0] m_diff = '0;
  logic             m_bout = 1'b0;
  logic             m_ovf  = 1'b0;
  logic [WIDTH-1:0] p_diff = '0;
  logic             p_bout = 1'b0;
  logic             p_ovf  = 1'b0;
  int               m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    logic [WIDTH:0] ext;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_diff = '0;
      m_bout = 1'b0;
      m_ovf  = 1'b0;
      m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_diff = p_diff;
          m_bout = p_bout;
          m_ovf  = p_ovf;
        end
      end else if (start) begin
        ext    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
        p_diff = ext[WIDTH-1:0];
        p_bout = ({1'b0, a} < ({1'b0, b} + {{WIDTH{1'b0}}, bin}));
        p_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (p_diff[WIDTH-1] != a[WIDTH-1]);
        m_busy = 1'b1;
        m_left = WIDTH;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("diff", {28'd0, diff}, {28'd0, m_diff});
    chk("bout", {31'd0, bout}, {31'd0, m_bout});
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
`endif
  end

  // Drive an op at a negedge and return at the negedge where done is seen (bounded).
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                        input logic tbin, output int cycles);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cycles++;
    end while (!done && cycles < 12);
    chk("latency", cycles, WIDTH + 1);
  endtask

  int n;
  int dones;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_diff", {28'd0, diff}, 0);
    chk("rst_bout", {31'd0, bout}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'h9, 4'h3, 1'b0, n);
    chk("d9m3", {28'd0, diff}, 32'h6);
    chk("b9m3", {31'd0, bout}, 0);
    @(negedge clk);
    chk("done_fall", {31'd0, done}, 0);

    run_op(4'h3, 4'h9, 1'b0, n);
    chk("d3m9", {28'd0, diff}, 32'hA);
    chk("b3m9", {31'd0, bout}, 1);
    run_op(4'h5, 4'h5, 1'b1, n);
    chk("d5m5b", {28'd0, diff}, 32'hF);
    chk("b5m5b", {31'd0, bout}, 1);
    @(negedge clk);

    // start re-asserted during RUN must be ignored.
    a = 4'hC; b = 4'h4; bin = 1'b0; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n <= 3) begin
        start = 1'b1; a = 4'h1; b = 4'h1;
      end else begin
        start = 1'b0;
      end
    end while (!done && n < 12);
    chk("ign_lat", n, WIDTH + 1);
    chk("ign_diff", {28'd0, diff}, 32'h8);
    chk("ign_bout", {31'd0, bout}, 0);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("ign_no2nd", dones, 0);

    // Start held in the done cycle: back-to-back operation.
    run_op(4'h9, 4'h3, 1'b0, n);
    a = 4'h7; b = 4'h2; bin = 1'b0; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (!done) chk("hold_diff", {28'd0, diff}, 32'h6);
    end while (!done && n < 12);
    chk("b2b_lat", n, WIDTH + 1);
    chk("b2b_diff", {28'd0, diff}, 32'h5);

    // Reset mid-operation.
    @(negedge clk);
    a = 4'hF; b = 4'h1; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_done", {31'd0, done}, 0);
    chk("arst_diff", {28'd0, diff}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'h2, 4'h1, 1'b0, n);
    chk("post_rst_diff", {28'd0, diff}, 32'h1);
    chk("post_rst_bout", {31'd0, bout}, 0);

`ifdef SERIAL_SUB_OVF_EN
    run_op(4'h8, 4'h1, 1'b0, n);
    chk("ovf_diff", {28'd0, diff}, 32'h7);
    chk("ovf_set", {31'd0, ovf}, 1);
    chk("ovf_bout", {31'd0, bout}, 0);
    run_op(4'h7, 4'h1, 1'b0, n);
    chk("ovf_clr", {31'd0, ovf}, 0);
`endif

    // Random traffic, including occasional async resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
      end
      start = ($urandom_range(0, 2) == 0);
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      bin   = 1'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (WIDTH + 3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
